// File: rtl/univ_cnt_pkg.sv
// Shared types for the programmable-modulus universal counter.
package univ_cnt_pkg;

    // Counting behaviour when a step crosses a bound; encoding 3 acts as MODE_SAT.
    typedef enum logic [1:0] {
        MODE_WRAP    = 2'd0,
        MODE_SAT     = 2'd1,
        MODE_ONESHOT = 2'd2
    } mode_e;

    // Run-state of the counter; DONE is only reachable in MODE_ONESHOT.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/mod_step_unit.sv
// Combinational next-count calculation for the modulus counter.
// All arithmetic is done one bit wider than the count so sums and
// borrows never alias back into the 0..lim range.
module mod_step_unit
    import univ_cnt_pkg::*;
#(
    parameter int unsigned N      = 8,
    parameter int unsigned STEP_W = 4
) (
    input  logic [N-1:0]      q,
    input  logic [STEP_W-1:0] step,
    input  logic [N-1:0]      lim,
    input  logic              up,
    input  logic [1:0]        mode,
    output logic [N-1:0]      nxt,
    output logic              wrap,
    output logic              hit_bound
);

    logic [N:0] q_x;
    logic [N:0] lim_x;
    logic [N:0] step_x;
    logic [N:0] sum;
    logic [N:0] diff;
    logic [N:0] wrap_up;
    logic [N:0] wrap_dn;

    assign q_x     = {1'b0, q};
    assign lim_x   = {1'b0, lim};
    assign step_x  = {{(N+1-STEP_W){1'b0}}, step};
    assign sum     = q_x + step_x;
    assign diff    = q_x - step_x;
    assign wrap_up = sum - (lim_x + (N+1)'(1));
    // A step larger than the whole range underflows here; the clamp below catches it.
    assign wrap_dn = q_x + lim_x + (N+1)'(1) - step_x;

    // Select the next count and flag a wrap according to direction and mode.
    always_comb begin
        nxt  = q;
        wrap = 1'b0;
        if (step_x == '0) begin
            nxt = q;
        end else if (up) begin
            if (sum <= lim_x) begin
                nxt = sum[N-1:0];
            end else if (mode == MODE_WRAP) begin
                nxt  = (wrap_up > lim_x) ? lim : wrap_up[N-1:0];
                wrap = 1'b1;
            end else begin
                nxt = lim;
            end
        end else begin
            if (q_x >= step_x) begin
                nxt = diff[N-1:0];
            end else if (mode == MODE_WRAP) begin
                nxt  = (wrap_dn > lim_x) ? lim : wrap_dn[N-1:0];
                wrap = 1'b1;
            end else begin
                nxt = '0;
            end
        end
    end

    assign hit_bound = up ? (nxt == lim) : (nxt == '0);

endmodule

// File: rtl/univ_mod_counter.sv
// Programmable-modulus up/down counter with runtime limit, variable step,
// WRAP / SAT / ONESHOT modes and a registered one-cycle wrap pulse.
module univ_mod_counter
    import univ_cnt_pkg::*;
#(
    parameter int unsigned    N             = 8,
    parameter int unsigned    STEP_W        = 4,
    parameter logic [N-1:0]   DEFAULT_LIMIT = '1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              syn_clr,
    input  logic              load,
    input  logic              en,
    input  logic              up,
    input  logic [1:0]        mode,
    input  logic [STEP_W-1:0] step,
    input  logic [N-1:0]      d,
    input  logic [N-1:0]      limit,
    input  logic              limit_we,
    output logic [N-1:0]      q,
    output logic              max_tick,
    output logic              min_tick,
    output logic              wrap_pulse,
    output logic              busy,
    output logic              done
);

    logic [N-1:0] lim_reg;
    state_e       state;
    logic [N-1:0] nxt;
    logic         wrap;
    logic         hit_bound;

    mod_step_unit #(
        .N      (N),
        .STEP_W (STEP_W)
    ) u_step (
        .q         (q),
        .step      (step),
        .lim       (lim_reg),
        .up        (up),
        .mode      (mode),
        .nxt       (nxt),
        .wrap      (wrap),
        .hit_bound (hit_bound)
    );

    // Count, limit, FSM and wrap-pulse registers with clr > load > clamp > en priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            q          <= '0;
            lim_reg    <= DEFAULT_LIMIT;
            state      <= ST_IDLE;
            wrap_pulse <= 1'b0;
        end else begin
            wrap_pulse <= 1'b0;
            if (limit_we) begin
                lim_reg <= limit;
            end
            if (syn_clr) begin
                q     <= '0;
                state <= ST_IDLE;
            end else if (load) begin
                q     <= (d > lim_reg) ? lim_reg : d;
                state <= ST_IDLE;
            end else if (q > lim_reg) begin
                q <= lim_reg;
            end else if (en && (state != ST_DONE)) begin
                q          <= nxt;
                wrap_pulse <= wrap;
                state      <= ((mode == MODE_ONESHOT) && hit_bound) ? ST_DONE : ST_RUN;
            end
        end
    end

    assign max_tick = (q == lim_reg);
    assign min_tick = (q == '0);
    assign busy     = (state == ST_RUN);
    assign done     = (state == ST_DONE);

endmodule

// File: tb/tb_univ_mod_counter.sv
// Directed self-checking bench for univ_mod_counter (N=8, STEP_W=4).
module tb_univ_mod_counter;

    logic       clk = 1'b0;
    logic       rst, syn_clr, load, en, up, limit_we;
    logic [1:0] mode;
    logic [3:0] step;
    logic [7:0] d, limit;
    logic [7:0] q;
    logic       max_tick, min_tick, wrap_pulse, busy, done;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    univ_mod_counter #(
        .N      (8),
        .STEP_W (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .syn_clr    (syn_clr),
        .load       (load),
        .en         (en),
        .up         (up),
        .mode       (mode),
        .step       (step),
        .d          (d),
        .limit      (limit),
        .limit_we   (limit_we),
        .q          (q),
        .max_tick   (max_tick),
        .min_tick   (min_tick),
        .wrap_pulse (wrap_pulse),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst = 1'b0; syn_clr = 1'b0; load = 1'b0; en = 1'b0; limit_we = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; syn_clr = 1'b0; load = 1'b0; en = 1'b0; up = 1'b1;
        mode = 2'd0; step = 4'd1; d = 8'd0; limit = 8'd0; limit_we = 1'b0;
        tick(); tick();
        n_cmp++; if (q !== 8'd0) begin n_err++; $display("FAIL reset_q q=%0d exp=0", q); end
        n_cmp++; if ({busy, done, wrap_pulse} !== 3'b000) begin n_err++; $display("FAIL reset_flags busy/done/wrap=%b exp=000", {busy, done, wrap_pulse}); end
        n_cmp++; if ({max_tick, min_tick} !== 2'b01) begin n_err++; $display("FAIL reset_ticks max/min=%b exp=01", {max_tick, min_tick}); end
    endtask

    task automatic test_wrap_up();
        idle_inputs();
        limit_we = 1'b1; limit = 8'd9; tick();
        limit_we = 1'b0; mode = 2'd0; up = 1'b1; step = 4'd3; en = 1'b1;
        tick();
        n_cmp++; if ({q, busy, wrap_pulse} !== {8'd3, 1'b1, 1'b0}) begin n_err++; $display("FAIL wrap_up_3 q=%0d busy=%b wp=%b exp=3,1,0", q, busy, wrap_pulse); end
        tick();
        n_cmp++; if ({q, wrap_pulse} !== {8'd6, 1'b0}) begin n_err++; $display("FAIL wrap_up_6 q=%0d wp=%b exp=6,0", q, wrap_pulse); end
        tick();
        n_cmp++; if ({q, max_tick, wrap_pulse} !== {8'd9, 1'b1, 1'b0}) begin n_err++; $display("FAIL wrap_up_9 q=%0d max=%b wp=%b exp=9,1,0", q, max_tick, wrap_pulse); end
        tick();
        n_cmp++; if ({q, max_tick, wrap_pulse} !== {8'd2, 1'b0, 1'b1}) begin n_err++; $display("FAIL wrap_up_2 q=%0d max=%b wp=%b exp=2,0,1", q, max_tick, wrap_pulse); end
        en = 1'b0; tick();
        n_cmp++; if ({q, wrap_pulse} !== {8'd2, 1'b0}) begin n_err++; $display("FAIL wrap_up_pulse_end q=%0d wp=%b exp=2,0", q, wrap_pulse); end
    endtask

    task automatic test_sat_down();
        idle_inputs();
        limit_we = 1'b1; limit = 8'd20; tick();
        limit_we = 1'b0; load = 1'b1; d = 8'd10; tick();
        n_cmp++; if ({q, busy} !== {8'd10, 1'b0}) begin n_err++; $display("FAIL sat_load q=%0d busy=%b exp=10,0", q, busy); end
        load = 1'b0; mode = 2'd1; up = 1'b0; step = 4'd4; en = 1'b1;
        tick();
        n_cmp++; if ({q, wrap_pulse} !== {8'd6, 1'b0}) begin n_err++; $display("FAIL sat_dn_6 q=%0d wp=%b exp=6,0", q, wrap_pulse); end
        tick();
        n_cmp++; if ({q, min_tick} !== {8'd2, 1'b0}) begin n_err++; $display("FAIL sat_dn_2 q=%0d min=%b exp=2,0", q, min_tick); end
        tick();
        n_cmp++; if ({q, min_tick, wrap_pulse} !== {8'd0, 1'b1, 1'b0}) begin n_err++; $display("FAIL sat_dn_0 q=%0d min=%b wp=%b exp=0,1,0", q, min_tick, wrap_pulse); end
        tick();
        n_cmp++; if ({q, min_tick, wrap_pulse, done} !== {8'd0, 1'b1, 1'b0, 1'b0}) begin n_err++; $display("FAIL sat_dn_hold q=%0d min=%b wp=%b done=%b exp=0,1,0,0", q, min_tick, wrap_pulse, done); end
        // Encoding 3 behaves as SAT: from 2 with step 4 down, go to 0 without wrapping.
        en = 1'b0; load = 1'b1; d = 8'd2; tick();
        load = 1'b0; mode = 2'd3; en = 1'b1; tick();
        n_cmp++; if ({q, wrap_pulse} !== {8'd0, 1'b0}) begin n_err++; $display("FAIL mode3_sat q=%0d wp=%b exp=0,0", q, wrap_pulse); end
    endtask

    task automatic test_oneshot();
        idle_inputs();
        limit_we = 1'b1; limit = 8'd5; syn_clr = 1'b1; tick();
        n_cmp++; if ({q, busy} !== {8'd0, 1'b0}) begin n_err++; $display("FAIL os_clr q=%0d busy=%b exp=0,0", q, busy); end
        limit_we = 1'b0; syn_clr = 1'b0; mode = 2'd2; up = 1'b1; step = 4'd2; en = 1'b1;
        tick();
        n_cmp++; if ({q, busy, done} !== {8'd2, 1'b1, 1'b0}) begin n_err++; $display("FAIL os_2 q=%0d busy=%b done=%b exp=2,1,0", q, busy, done); end
        tick();
        n_cmp++; if ({q, busy, done} !== {8'd4, 1'b1, 1'b0}) begin n_err++; $display("FAIL os_4 q=%0d busy=%b done=%b exp=4,1,0", q, busy, done); end
        tick();
        n_cmp++; if ({q, busy, done, max_tick, wrap_pulse} !== {8'd5, 1'b0, 1'b1, 1'b1, 1'b0}) begin n_err++; $display("FAIL os_5_done q=%0d busy=%b done=%b max=%b wp=%b exp=5,0,1,1,0", q, busy, done, max_tick, wrap_pulse); end
        tick();
        n_cmp++; if ({q, done} !== {8'd5, 1'b1}) begin n_err++; $display("FAIL os_hold q=%0d done=%b exp=5,1", q, done); end
        mode = 2'd0; tick();
        n_cmp++; if ({q, done, wrap_pulse} !== {8'd5, 1'b1, 1'b0}) begin n_err++; $display("FAIL os_mode_change q=%0d done=%b wp=%b exp=5,1,0", q, done, wrap_pulse); end
        en = 1'b0; load = 1'b1; d = 8'd1; tick();
        n_cmp++; if ({q, done, busy} !== {8'd1, 1'b0, 1'b0}) begin n_err++; $display("FAIL os_reload q=%0d done=%b busy=%b exp=1,0,0", q, done, busy); end
    endtask

    task automatic test_priority();
        idle_inputs();
        syn_clr = 1'b1; load = 1'b1; d = 8'd3; en = 1'b1; mode = 2'd0; up = 1'b1; step = 4'd1;
        tick();
        n_cmp++; if ({q, busy} !== {8'd0, 1'b0}) begin n_err++; $display("FAIL prio_clr q=%0d busy=%b exp=0,0", q, busy); end
        idle_inputs();
        limit_we = 1'b1; limit = 8'd100; tick();
        limit_we = 1'b0; load = 1'b1; d = 8'd200; tick();
        n_cmp++; if ({q, max_tick} !== {8'd100, 1'b1}) begin n_err++; $display("FAIL load_clamp q=%0d max=%b exp=100,1", q, max_tick); end
    endtask

    task automatic test_limit_write();
        idle_inputs();
        load = 1'b1; d = 8'd50; tick();
        load = 1'b0; limit_we = 1'b1; limit = 8'd20; en = 1'b1; up = 1'b1; step = 4'd1; mode = 2'd0;
        tick();
        n_cmp++; if ({q, max_tick} !== {8'd51, 1'b0}) begin n_err++; $display("FAIL limwr_old q=%0d max=%b exp=51,0", q, max_tick); end
        limit_we = 1'b0; tick();
        n_cmp++; if ({q, max_tick, wrap_pulse} !== {8'd20, 1'b1, 1'b0}) begin n_err++; $display("FAIL limwr_clamp q=%0d max=%b wp=%b exp=20,1,0", q, max_tick, wrap_pulse); end
        en = 1'b0;
    endtask

    task automatic test_wrap_down();
        idle_inputs();
        limit_we = 1'b1; limit = 8'd9; tick();
        limit_we = 1'b0; load = 1'b1; d = 8'd1; tick();
        load = 1'b0; mode = 2'd0; up = 1'b0; step = 4'd3; en = 1'b1;
        tick();
        n_cmp++; if ({q, wrap_pulse} !== {8'd8, 1'b1}) begin n_err++; $display("FAIL wrap_dn q=%0d wp=%b exp=8,1", q, wrap_pulse); end
        en = 1'b0; tick();
        n_cmp++; if ({q, wrap_pulse} !== {8'd8, 1'b0}) begin n_err++; $display("FAIL wrap_dn_end q=%0d wp=%b exp=8,0", q, wrap_pulse); end
        up = 1'b1; step = 4'd0; en = 1'b1; tick();
        n_cmp++; if ({q, wrap_pulse} !== {8'd8, 1'b0}) begin n_err++; $display("FAIL step0_hold q=%0d wp=%b exp=8,0", q, wrap_pulse); end
    endtask

    task automatic test_reset_mid_run();
        idle_inputs();
        mode = 2'd0; up = 1'b1; step = 4'd1; en = 1'b1;
        tick();
        n_cmp++; if ({q, busy, max_tick} !== {8'd9, 1'b1, 1'b1}) begin n_err++; $display("FAIL mid_run q=%0d busy=%b max=%b exp=9,1,1", q, busy, max_tick); end
        // Reset on the edge that would otherwise wrap 9 -> 0.
        rst = 1'b1; tick();
        n_cmp++; if ({q, busy, done, wrap_pulse} !== {8'd0, 1'b0, 1'b0, 1'b0}) begin n_err++; $display("FAIL rst_mid q=%0d busy=%b done=%b wp=%b exp=0,0,0,0", q, busy, done, wrap_pulse); end
        idle_inputs();
        load = 1'b1; d = 8'd255; tick();
        n_cmp++; if ({q, max_tick} !== {8'd255, 1'b1}) begin n_err++; $display("FAIL rst_lim q=%0d max=%b exp=255,1", q, max_tick); end
    endtask

    task automatic test_legacy_wrap();
        idle_inputs();
        mode = 2'd0; up = 1'b1; step = 4'd1; en = 1'b1;
        tick();
        n_cmp++; if ({q, wrap_pulse, min_tick} !== {8'd0, 1'b1, 1'b1}) begin n_err++; $display("FAIL legacy_wrap q=%0d wp=%b min=%b exp=0,1,1", q, wrap_pulse, min_tick); end
        tick();
        n_cmp++; if ({q, wrap_pulse} !== {8'd1, 1'b0}) begin n_err++; $display("FAIL legacy_next q=%0d wp=%b exp=1,0", q, wrap_pulse); end
        en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_wrap_up();
        test_sat_down();
        test_oneshot();
        test_priority();
        test_limit_write();
        test_wrap_down();
        test_reset_mid_run();
        test_legacy_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
